keystream_pixel_xor: RTL



---
 rtl/keystream_pixel_xor_pkg.sv | 18 +
 rtl/keystream_pixel_xor_ks_byte_packer.sv | 52 +++++
 rtl/keystream_pixel_xor.sv | 116 +++++++++++
 3 files changed

// File: rtl/keystream_pixel_xor_pkg.sv
// Shared types and helpers for the keystream pixel encryption block.
package keystream_pixel_xor_pkg;

    localparam int PIXEL_W_DEF    = 8;
    localparam int NUM_PIXELS_DEF = 16384;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A valid/ready transfer happens when both sides agree in the same cycle.
    function automatic logic fire(input logic valid, input logic ready);
        return valid && ready;
    endfunction

endpackage

// File: rtl/keystream_pixel_xor_ks_byte_packer.sv
// Packs serial keystream bits MSB-first into a key byte and holds it until consumed.
module ks_byte_packer
    import keystream_pixel_xor_pkg::*;
#(
    parameter int PIXEL_W = PIXEL_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               ks_bit,
    input  logic               ks_valid,
    output logic               ks_ready,
    input  logic               consume,
    output logic [PIXEL_W-1:0] key,
    output logic               key_full
);

    localparam int CNT_W = (PIXEL_W > 1) ? $clog2(PIXEL_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PIXEL_W - 1);

    logic [CNT_W-1:0] bit_cnt;
    logic             bit_fire;

    // Accept bits only while enabled and no complete byte is waiting.
    always_comb begin
        ks_ready = enable && !key_full;
        bit_fire = fire(ks_valid, ks_ready);
    end

    // Shift register, bit counter and full flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt  <= '0;
            key      <= '0;
            key_full <= 1'b0;
        end else begin
            if (consume) begin
                key_full <= 1'b0;
            end
            if (bit_fire) begin
                key <= {key[PIXEL_W-2:0], ks_bit};
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt  <= '0;
                    key_full <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/keystream_pixel_xor.sv
// XORs each image pixel with a key byte packed from the A5/1 keystream and
// streams the ciphertext out, tracking pixels per frame.
module keystream_pixel_xor
    import keystream_pixel_xor_pkg::*;
#(
    parameter int PIXEL_W    = PIXEL_W_DEF,
    parameter int NUM_PIXELS = NUM_PIXELS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               ks_bit,
    input  logic               ks_valid,
    output logic               ks_ready,
    input  logic [PIXEL_W-1:0] pix_data,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [PIXEL_W-1:0] enc_data,
    output logic               enc_valid,
    input  logic               enc_ready,
    output logic               enc_last,
    output logic               frame_done
);

    localparam int CNT_W = $clog2(NUM_PIXELS + 1);
    localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(NUM_PIXELS);

    state_t             state;
    state_t             state_next;
    logic               frame_start;
    logic [CNT_W-1:0]   pix_cnt;
    logic               pix_left;
    logic [PIXEL_W-1:0] key;
    logic               key_full;
    logic               ks_enable;
    logic               pix_fire;
    logic               enc_fire;

    ks_byte_packer #(.PIXEL_W(PIXEL_W)) u_packer (
        .clk      (clk),
        .reset    (reset),
        .enable   (ks_enable),
        .ks_bit   (ks_bit),
        .ks_valid (ks_valid),
        .ks_ready (ks_ready),
        .consume  (pix_fire),
        .key      (key),
        .key_full (key_full)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start opens a frame from IDLE or DONE; the final output transfer closes it.
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_next  = RUN;
                frame_start = 1'b1;
            end
            RUN:  if (enc_fire && enc_last) state_next = DONE;
            DONE: if (start) begin
                state_next  = RUN;
                frame_start = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake readiness; keystream intake is also gated on pixels remaining
    // so no surplus key bits are drawn while the last output drains.
    always_comb begin
        pix_left   = (pix_cnt < PIX_TOTAL);
        frame_done = (state == DONE);
        ks_enable  = (state == RUN) && pix_left;
        pix_ready  = (state == RUN) && key_full && (!enc_valid || enc_ready) && pix_left;
        pix_fire   = fire(pix_valid, pix_ready);
        enc_fire   = fire(enc_valid, enc_ready);
    end

    // Pixel counter, cleared whenever a frame begins.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt <= '0;
        end else if (frame_start) begin
            pix_cnt <= '0;
        end else if (pix_fire) begin
            pix_cnt <= pix_cnt + CNT_W'(1);
        end
    end

    // Output register: loads on pixel accept, drains on output accept, holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            enc_data  <= '0;
            enc_valid <= 1'b0;
            enc_last  <= 1'b0;
        end else if (pix_fire) begin
            enc_data  <= pix_data ^ key;
            enc_valid <= 1'b1;
            enc_last  <= ((pix_cnt + CNT_W'(1)) == PIX_TOTAL);
        end else if (enc_fire) begin
            enc_valid <= 1'b0;
            enc_last  <= 1'b0;
        end
    end

endmodule
